// File: rtl/pid_incr_ctrl_if.sv
// Sample-in / count-out bundle of the incremental PI regulator.
interface pid_incr_ctrl_if #(
    parameter int ADC_W = 12,
    parameter int OUT_W = 12
);
    logic             sample_valid;
    logic [ADC_W-1:0] sample;
    logic [OUT_W-1:0] out_cnt;
    logic             out_valid;
    logic             sat_hi;
    logic             sat_lo;
    logic             sample_drop;

    modport master (
        output sample_valid, sample,
        input  out_cnt, out_valid, sat_hi, sat_lo, sample_drop
    );

    modport slave (
        input  sample_valid, sample,
        output out_cnt, out_valid, sat_hi, sat_lo, sample_drop
    );
endinterface

// File: rtl/pid_incr_ctrl.sv
// Incremental PI regulator: ADC sample -> clamped count word, with key-driven setpoint.
// state | meaning
// IDLE  | waiting for a sample strobe (accepted only while run=1)
// ERR   | error e = sp - sample latched
// TERM  | integral/proportional terms latched, e_last updated
// ACC   | out_cnt/sat flags just updated, out_valid high
module pid_incr_ctrl #(
    parameter int ADC_W       = 12,
    parameter int OUT_W       = 12,
    parameter int KI_SHIFT    = 3,
    parameter int KP_SHIFT    = 1,
    parameter int POLARITY    = 0,
    parameter int OUT_MIN     = 416,
    parameter int OUT_MAX     = 625,
    parameter int OUT_DEFAULT = 520,
    parameter int SP_DEFAULT  = 3430,
    parameter int SP_STEP     = 5,
    parameter int SP_MIN      = 0,
    parameter int SP_MAX      = 4000
) (
    input  logic             clk,
    input  logic             rstp,
    input  logic             run,
    input  logic             key_up,
    input  logic             key_dn,
    output logic [ADC_W-1:0] sp_out,
    pid_incr_ctrl_if.slave   bus
);
    localparam int E_W  = ADC_W + 1;
    localparam int D_W  = ADC_W + 2;
    localparam int S_W  = OUT_W + ADC_W + 3;
    localparam int SP_W = ADC_W + 2;

    localparam logic signed [S_W-1:0]  OUT_MIN_S = S_W'(OUT_MIN);
    localparam logic signed [S_W-1:0]  OUT_MAX_S = S_W'(OUT_MAX);
    localparam logic signed [SP_W-1:0] SP_STEP_S = SP_W'(SP_STEP);
    localparam logic signed [SP_W-1:0] SP_MIN_S  = SP_W'(SP_MIN);
    localparam logic signed [SP_W-1:0] SP_MAX_S  = SP_W'(SP_MAX);

    typedef enum logic [1:0] {IDLE, ERR, TERM, ACC} state_t;

    state_t                  state_q, state_d;
    logic signed [E_W-1:0]   e_q, e_last_q;
    logic signed [D_W-1:0]   ti_q, tp_q;
    logic                    first_q;
    logic [OUT_W-1:0]        out_cnt_q;
    logic                    out_valid_q, sat_hi_q, sat_lo_q, drop_q;
    logic [ADC_W-1:0]        sp_q;
    logic [2:0]              up_sync_q, dn_sync_q;

    logic                    load_e, load_t, load_o, drop_d;
    logic signed [E_W-1:0]   e_calc;
    logic signed [D_W-1:0]   e_ext, e_last_ext, de_calc, ti_calc, tp_calc;
    logic signed [D_W:0]     delta;
    logic signed [S_W-1:0]   out_ext, delta_ext, s_calc;
    logic                    sat_hi_d, sat_lo_d;
    logic [OUT_W-1:0]        out_next;
    logic                    up_edge, dn_edge;
    logic signed [SP_W-1:0]  sp_ext, sp_up_w, sp_dn_w;
    logic [ADC_W-1:0]        sp_next;

    always_comb begin
        state_d = state_q;
        load_e  = 1'b0;
        load_t  = 1'b0;
        load_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sample_valid) begin
                    state_d = ERR;
                    load_e  = 1'b1;
                end
            end
            ERR: begin
                state_d = TERM;
                load_t  = 1'b1;
            end
            TERM: begin
                state_d = ACC;
                load_o  = 1'b1;
            end
            ACC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Dropping run aborts whatever is in flight, including the strobe in this cycle.
        if (!run) begin
            state_d = IDLE;
            load_e  = 1'b0;
            load_t  = 1'b0;
            load_o  = 1'b0;
        end
        drop_d = bus.sample_valid && (state_q != IDLE || !run);
    end

    assign e_calc     = $signed({1'b0, sp_q}) - $signed({1'b0, bus.sample});
    assign e_ext      = {e_q[E_W-1], e_q};
    assign e_last_ext = {e_last_q[E_W-1], e_last_q};
    assign de_calc    = first_q ? '0 : (e_ext - e_last_ext);
    assign ti_calc    = e_ext >>> KI_SHIFT;
    assign tp_calc    = de_calc >>> KP_SHIFT;

    assign delta     = {ti_q[D_W-1], ti_q} + {tp_q[D_W-1], tp_q};
    assign out_ext   = {{(S_W-OUT_W){1'b0}}, out_cnt_q};
    assign delta_ext = {{(S_W-D_W-1){delta[D_W]}}, delta};
    assign s_calc    = (POLARITY != 0) ? (out_ext - delta_ext) : (out_ext + delta_ext);
    assign sat_hi_d  = s_calc > OUT_MAX_S;
    assign sat_lo_d  = s_calc < OUT_MIN_S;
    assign out_next  = sat_hi_d ? OUT_W'(OUT_MAX) :
                       sat_lo_d ? OUT_W'(OUT_MIN) : s_calc[OUT_W-1:0];

    assign up_edge = up_sync_q[1] & ~up_sync_q[2];
    assign dn_edge = dn_sync_q[1] & ~dn_sync_q[2];
    assign sp_ext  = {2'b00, sp_q};
    assign sp_up_w = sp_ext + SP_STEP_S;
    assign sp_dn_w = sp_ext - SP_STEP_S;

    always_comb begin
        sp_next = sp_q;
        if (up_edge && !dn_edge)
            sp_next = (sp_up_w > SP_MAX_S) ? ADC_W'(SP_MAX) : sp_up_w[ADC_W-1:0];
        else if (dn_edge && !up_edge)
            sp_next = (sp_dn_w < SP_MIN_S) ? ADC_W'(SP_MIN) : sp_dn_w[ADC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            state_q     <= IDLE;
            e_q         <= '0;
            e_last_q    <= '0;
            ti_q        <= '0;
            tp_q        <= '0;
            first_q     <= 1'b1;
            out_cnt_q   <= OUT_W'(OUT_DEFAULT);
            out_valid_q <= 1'b0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            drop_q      <= 1'b0;
            sp_q        <= ADC_W'(SP_DEFAULT);
            up_sync_q   <= '0;
            dn_sync_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= load_o;
            drop_q      <= drop_d;
            if (load_e)
                e_q <= e_calc;
            if (load_t) begin
                ti_q     <= ti_calc;
                tp_q     <= tp_calc;
                e_last_q <= e_q;
            end
            if (!run)
                first_q <= 1'b1;
            else if (load_t)
                first_q <= 1'b0;
            if (load_o) begin
                out_cnt_q <= out_next;
                sat_hi_q  <= sat_hi_d;
                sat_lo_q  <= sat_lo_d;
            end
            up_sync_q <= {up_sync_q[1:0], key_up};
            dn_sync_q <= {dn_sync_q[1:0], key_dn};
            sp_q      <= sp_next;
        end
    end

    assign bus.out_cnt     = out_cnt_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.sat_hi      = sat_hi_q;
    assign bus.sat_lo      = sat_lo_q;
    assign bus.sample_drop = drop_q;
    assign sp_out          = sp_q;
endmodule
